// File: rtl/ibex_axil_bridge_pipe.sv
// Pipelined Ibex LSU to AXI4-Lite master bridge: in-order, single-direction
// outstanding window, independent AW/W channels and a registered response path.
module ibex_axil_bridge_pipe #(
    parameter int AXI_AW          = 16,
    parameter int AXI_DW          = 32,
    parameter int IBEX_AW         = 32,
    parameter int IBEX_DW         = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   req_i,
    output logic                   gnt_o,
    output logic                   rvalid_o,
    input  logic                   we_i,
    input  logic [IBEX_DW/8-1:0]   be_i,
    input  logic [IBEX_AW-1:0]     addr_i,
    input  logic [IBEX_DW-1:0]     wdata_i,
    output logic [IBEX_DW-1:0]     rdata_o,
    output logic                   err_o,

    output logic [AXI_AW-1:0]      aw_addr_o,
    output logic                   aw_valid_o,
    input  logic                   aw_ready_i,
    output logic [AXI_DW-1:0]      w_data_o,
    output logic [AXI_DW/8-1:0]    w_strb_o,
    output logic                   w_valid_o,
    input  logic                   w_ready_i,
    input  logic [1:0]             b_resp_i,
    input  logic                   b_valid_i,
    output logic                   b_ready_o,
    output logic [AXI_AW-1:0]      ar_addr_o,
    output logic                   ar_valid_o,
    input  logic                   ar_ready_i,
    input  logic [AXI_DW-1:0]      r_data_i,
    input  logic [1:0]             r_resp_i,
    input  logic                   r_valid_i,
    output logic                   r_ready_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   dir_q, dir_d;
    logic                   lerr_q, lerr_d;
    logic                   ar_valid_q, ar_valid_d;
    logic [AXI_AW-1:0]      ar_addr_q, ar_addr_d;
    logic                   aw_valid_q, aw_valid_d;
    logic [AXI_AW-1:0]      aw_addr_q, aw_addr_d;
    logic                   w_valid_q, w_valid_d;
    logic [AXI_DW-1:0]      w_data_q, w_data_d;
    logic [AXI_DW/8-1:0]    w_strb_q, w_strb_d;
    logic                   rvalid_q, rvalid_d;
    logic [IBEX_DW-1:0]     rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic oor;
    logic cnt_zero, cmd_busy, slot_ok, gnt, gnt_axi, r_hs, b_hs, resp_hs;

    // Only the low resp bit is ignored: OKAY/EXOKAY both map to no error.
    logic unused_resp;
    assign unused_resp = ^{r_resp_i[0], b_resp_i[0]};

    if (AXI_AW < IBEX_AW) begin : g_oor
        assign oor = |addr_i[IBEX_AW-1:AXI_AW];
    end else begin : g_no_oor
        assign oor = 1'b0;
    end

    always_comb begin
        cnt_zero = (cnt_q == '0);
        cmd_busy = ar_valid_q | aw_valid_q | w_valid_q;
        slot_ok  = ~oor & (cnt_q < CNT_MAX) & (cnt_zero | (dir_q == we_i));
        gnt      = req_i & ~cmd_busy & ~lerr_q & ~rst_i & (slot_ok | (oor & cnt_zero));
        gnt_axi  = gnt & ~oor;
        r_hs     = r_valid_i & ~cnt_zero & ~dir_q;
        b_hs     = b_valid_i & ~cnt_zero & dir_q;
        resp_hs  = r_hs | b_hs;
    end

    always_comb begin
        ar_valid_d = ar_valid_q & ~ar_ready_i;
        ar_addr_d  = ar_addr_q;
        aw_valid_d = aw_valid_q & ~aw_ready_i;
        aw_addr_d  = aw_addr_q;
        w_valid_d  = w_valid_q & ~w_ready_i;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        lerr_d     = gnt & oor;

        if (gnt_axi) begin
            dir_d = we_i;
            if (we_i) begin
                aw_valid_d = 1'b1;
                aw_addr_d  = addr_i[AXI_AW-1:0];
                w_valid_d  = 1'b1;
                w_data_d   = wdata_i;
                w_strb_d   = be_i;
            end else begin
                ar_valid_d = 1'b1;
                ar_addr_d  = addr_i[AXI_AW-1:0];
            end
        end

        if (gnt_axi && !resp_hs) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!gnt_axi && resp_hs) begin
            cnt_d = cnt_q - CW'(1);
        end

        // A local error can only be pending while nothing is outstanding.
        rvalid_d = resp_hs | lerr_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        if (r_hs) begin
            rdata_d = r_data_i;
            err_d   = r_resp_i[1];
        end else if (b_hs) begin
            rdata_d = '0;
            err_d   = b_resp_i[1];
        end else if (lerr_q) begin
            rdata_d = '0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            lerr_q     <= 1'b0;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            aw_valid_q <= 1'b0;
            aw_addr_q  <= '0;
            w_valid_q  <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            lerr_q     <= lerr_d;
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
            aw_valid_q <= aw_valid_d;
            aw_addr_q  <= aw_addr_d;
            w_valid_q  <= w_valid_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign gnt_o      = gnt;
    assign rvalid_o   = rvalid_q;
    assign rdata_o    = rdata_q;
    assign err_o      = err_q;
    assign aw_addr_o  = aw_addr_q;
    assign aw_valid_o = aw_valid_q;
    assign w_data_o   = w_data_q;
    assign w_strb_o   = w_strb_q;
    assign w_valid_o  = w_valid_q;
    assign ar_addr_o  = ar_addr_q;
    assign ar_valid_o = ar_valid_q;
    assign r_ready_o  = ~cnt_zero & ~dir_q;
    assign b_ready_o  = ~cnt_zero & dir_q;

endmodule

// File: tb/tb_ibex_axil_bridge_pipe.sv
// Directed cycle-by-cycle vectors for ibex_axil_bridge_pipe (defaults:
// AXI_AW=16, MAX_OUTSTANDING=2) plus a hand-written W-before-AW sequence.
module tb_ibex_axil_bridge_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, we, gnt, rvalid, err;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
    logic [15:0] aw_addr, ar_addr;
    logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic        ar_valid, ar_ready, r_valid, r_ready;
    logic [31:0] w_data, r_data;
    logic [3:0]  w_strb;
    logic [1:0]  b_resp, r_resp;

    ibex_axil_bridge_pipe dut (
        .clk_i(clk), .rst_i(rst),
        .req_i(req), .gnt_o(gnt), .rvalid_o(rvalid), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .err_o(err),
        .aw_addr_o(aw_addr), .aw_valid_o(aw_valid), .aw_ready_i(aw_ready),
        .w_data_o(w_data), .w_strb_o(w_strb), .w_valid_o(w_valid), .w_ready_i(w_ready),
        .b_resp_i(b_resp), .b_valid_i(b_valid), .b_ready_o(b_ready),
        .ar_addr_o(ar_addr), .ar_valid_o(ar_valid), .ar_ready_i(ar_ready),
        .r_data_i(r_data), .r_resp_i(r_resp), .r_valid_i(r_valid), .r_ready_o(r_ready)
    );

    typedef struct {
        logic rst, req, we; logic [31:0] addr, wdata; logic [3:0] be;
        logic arr, awr, wr, rv; logic [31:0] rd; logic [1:0] rr; logic bv; logic [1:0] br;
        logic gnt, arv, awv, wv, rrdy, brdy, rvld, err; logic [31:0] rdata;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic [15:0] m_ar = '0, m_aw = '0;
    logic [31:0] m_wd = '0;
    logic [3:0]  m_ws = '0;

    task automatic v(input logic rst_, req_, we_, input logic [31:0] addr_, wdata_, input logic [3:0] be_,
                     input logic arr_, awr_, wr_, rv_, input logic [31:0] rd_, input logic [1:0] rr_,
                     input logic bv_, input logic [1:0] br_,
                     input logic g, arv, awv, wv, rrdy, brdy, rvld, e, input logic [31:0] rdat);
        vec_t t;
        t.rst = rst_; t.req = req_; t.we = we_; t.addr = addr_; t.wdata = wdata_; t.be = be_;
        t.arr = arr_; t.awr = awr_; t.wr = wr_; t.rv = rv_; t.rd = rd_; t.rr = rr_; t.bv = bv_; t.br = br_;
        t.gnt = g; t.arv = arv; t.awv = awv; t.wv = wv; t.rrdy = rrdy; t.brdy = brdy;
        t.rvld = rvld; t.err = e; t.rdata = rdat;
        tbl.push_back(t);
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; req = t.req; we = t.we; addr = t.addr; wdata = t.wdata; be = t.be;
        ar_ready = t.arr; aw_ready = t.awr; w_ready = t.wr; r_valid = t.rv; r_data = t.rd;
        r_resp = t.rr; b_valid = t.bv; b_resp = t.br;
    endtask

    task automatic clr_in();
        req = 0; we = 0; addr = 0; wdata = 0; be = 0; ar_ready = 0; aw_ready = 0; w_ready = 0;
        r_valid = 0; r_data = 0; r_resp = 0; b_valid = 0; b_resp = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    initial begin
        logic [7:0] act_c, exp_c;
        logic       ok;

        rst = 1; clr_in();
        repeat (2) @(posedge clk);

        //  rst req we addr wdata be | arr awr wr rv rd rr bv br | gnt arv awv wv rrdy brdy rvld err rdata
        v(1,0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);
        // single read, ar_ready tied high
        v(0,1,0,'h10,0,0, 1,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0);
        v(0,0,0,0,0,0, 1,0,0,0,0,0,0,0, 0,1,0,0,1,0,0,0,0);
        v(0,0,0,0,0,0, 1,0,0,1,'hDEADBEEF,0,0,0, 0,0,0,0,1,0,0,0,0);
        v(0,0,0,0,0,0, 1,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0,'hDEADBEEF);
        v(0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,'hDEADBEEF);
        // write, W ready three cycles after AW; second write waits for W
        v(0,1,1,'h20,'hA5A50000,'hC, 0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,'hDEADBEEF);
        v(0,1,1,'h24,'h11112222,'hF, 0,1,0,0,0,0,0,0, 0,0,1,1,0,1,0,0,'hDEADBEEF);
        v(0,1,1,'h24,'h11112222,'hF, 0,0,0,0,0,0,0,0, 0,0,0,1,0,1,0,0,'hDEADBEEF);
        v(0,1,1,'h24,'h11112222,'hF, 0,0,0,0,0,0,0,0, 0,0,0,1,0,1,0,0,'hDEADBEEF);
        v(0,1,1,'h24,'h11112222,'hF, 0,0,1,0,0,0,0,0, 0,0,0,1,0,1,0,0,'hDEADBEEF);
        v(0,1,1,'h24,'h11112222,'hF, 0,1,1,0,0,0,1,0, 1,0,0,0,0,1,0,0,'hDEADBEEF);
        v(0,0,0,0,0,0, 0,1,1,0,0,0,0,0, 0,0,1,1,0,1,1,0,0);
        v(0,0,0,0,0,0, 0,0,0,0,0,0,1,2'b10, 0,0,0,0,0,1,0,0,0);
        v(0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,1,0);
        // three pipelined reads, window of two
        v(0,1,0,'h100,0,0, 1,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0);
        v(0,1,0,'h104,0,0, 1,0,0,0,0,0,0,0, 0,1,0,0,1,0,0,0,0);
        v(0,1,0,'h104,0,0, 1,0,0,0,0,0,0,0, 1,0,0,0,1,0,0,0,0);
        v(0,1,0,'h108,0,0, 1,0,0,0,0,0,0,0, 0,1,0,0,1,0,0,0,0);
        v(0,1,0,'h108,0,0, 1,0,0,1,'h11110001,0,0,0, 0,0,0,0,1,0,0,0,0);
        v(0,1,0,'h108,0,0, 1,0,0,1,'h22220002,0,0,0, 1,0,0,0,1,0,1,0,'h11110001);
        v(0,0,0,0,0,0, 1,0,0,0,0,0,0,0, 0,1,0,0,1,0,1,0,'h22220002);
        v(0,0,0,0,0,0, 1,0,0,1,'h33330003,0,0,0, 0,0,0,0,1,0,0,0,'h22220002);
        v(0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0,'h33330003);
        // read pending blocks a write until the R handshake has retired
        v(0,1,0,'h40,0,0, 1,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,'h33330003);
        v(0,1,1,'h44,'hCAFEF00D,'hF, 1,0,0,0,0,0,0,0, 0,1,0,0,1,0,0,0,'h33330003);
        v(0,1,1,'h44,'hCAFEF00D,'hF, 1,0,0,0,0,0,0,0, 0,0,0,0,1,0,0,0,'h33330003);
        v(0,1,1,'h44,'hCAFEF00D,'hF, 1,0,0,1,'h55AA55AA,0,0,0, 0,0,0,0,1,0,0,0,'h33330003);
        v(0,1,1,'h44,'hCAFEF00D,'hF, 0,0,0,0,0,0,0,0, 1,0,0,0,0,0,1,0,'h55AA55AA);
        v(0,0,0,0,0,0, 0,1,1,0,0,0,0,0, 0,0,1,1,0,1,0,0,'h55AA55AA);
        v(0,0,0,0,0,0, 0,0,0,0,0,0,1,0, 0,0,0,0,0,1,0,0,'h55AA55AA);
        v(0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0,0);
        // out-of-range, idle and then behind an outstanding read (which gets SLVERR)
        v(0,1,0,'h10000,0,0, 1,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0);
        v(0,0,0,0,0,0, 1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);
        v(0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,1,0);
        v(0,1,0,'h50,0,0, 1,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0);
        v(0,1,0,'h10000,0,0, 1,0,0,0,0,0,0,0, 0,1,0,0,1,0,0,0,0);
        v(0,1,0,'h10000,0,0, 1,0,0,1,'h77777777,2'b10,0,0, 0,0,0,0,1,0,0,0,0);
        v(0,1,0,'h10000,0,0, 1,0,0,0,0,0,0,0, 1,0,0,0,0,0,1,1,'h77777777);
        v(0,1,0,'h60,0,0, 1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,'h77777777);
        v(0,1,0,'h60,0,0, 1,0,0,0,0,0,0,0, 1,0,0,0,0,0,1,1,0);
        v(0,0,0,0,0,0, 1,0,0,0,0,0,0,0, 0,1,0,0,1,0,0,0,0);
        v(0,0,0,0,0,0, 1,0,0,1,'h12345678,0,0,0, 0,0,0,0,1,0,0,0,0);
        v(0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0,'h12345678);
        // reset while AR is waiting, stray R afterwards is ignored, fresh read works
        v(0,1,0,'h70,0,0, 0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,'h12345678);
        v(0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,1,0,0,1,0,0,0,'h12345678);
        v(1,1,0,'h74,0,0, 0,0,0,0,0,0,0,0, 0,1,0,0,1,0,0,0,'h12345678);
        v(0,0,0,0,0,0, 0,0,0,1,'h9999,0,0,0, 0,0,0,0,0,0,0,0,0);
        v(0,1,0,'h80,0,0, 1,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0);
        v(0,0,0,0,0,0, 1,0,0,0,0,0,0,0, 0,1,0,0,1,0,0,0,0);
        v(0,0,0,0,0,0, 1,0,0,1,'hBEEF0001,0,0,0, 0,0,0,0,1,0,0,0,0);
        v(0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0,'hBEEF0001);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            drive(tbl[i]);
            @(negedge clk);
            act_c = {gnt, ar_valid, aw_valid, w_valid, r_ready, b_ready, rvalid, err};
            exp_c = {tbl[i].gnt, tbl[i].arv, tbl[i].awv, tbl[i].wv, tbl[i].rrdy, tbl[i].brdy,
                     tbl[i].rvld, tbl[i].err};
            ok = (act_c === exp_c) && (rdata === tbl[i].rdata)
                 && (!tbl[i].arv || ar_addr === m_ar)
                 && (!tbl[i].awv || aw_addr === m_aw)
                 && (!tbl[i].wv || (w_data === m_wd && w_strb === m_ws));
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL vec %0d: got gnt/ar/aw/w/rr/br/rv/err=%b rdata=%h ar=%h aw=%h wd=%h ws=%h; want %b rdata=%h ar=%h aw=%h wd=%h ws=%h",
                         i, act_c, rdata, ar_addr, aw_addr, w_data, w_strb,
                         exp_c, tbl[i].rdata, m_ar, m_aw, m_wd, m_ws);
            end
            if (tbl[i].gnt && tbl[i].addr[31:16] == 16'h0) begin
                if (tbl[i].we) begin
                    m_aw = tbl[i].addr[15:0]; m_wd = tbl[i].wdata; m_ws = tbl[i].be;
                end else begin
                    m_ar = tbl[i].addr[15:0];
                end
            end
        end

        // W completes before AW; the next write must wait for AW too
        @(posedge clk); #1;
        clr_in(); req = 1; we = 1; addr = 'h90; wdata = 'h0BADF00D; be = 4'h3; w_ready = 1;
        @(negedge clk); chk("wfirst_gnt", gnt, 1);
        @(posedge clk); #1;
        clr_in(); w_ready = 1;
        @(negedge clk);
        chk("wfirst_awv", aw_valid, 1); chk("wfirst_wv", w_valid, 1);
        chk("wfirst_awaddr", aw_addr, 'h90); chk("wfirst_wdata", w_data, 'h0BADF00D);
        chk("wfirst_wstrb", w_strb, 4'h3);
        @(posedge clk); #1;
        clr_in(); req = 1; we = 1; addr = 'h94; wdata = 'h1;  be = 4'hF;
        @(negedge clk);
        chk("wdone_wv", w_valid, 0); chk("awhold_awv", aw_valid, 1);
        chk("awhold_addr", aw_addr, 'h90); chk("awhold_gnt", gnt, 0);
        @(posedge clk); #1;
        clr_in(); aw_ready = 1;
        @(negedge clk); chk("awlate_awv", aw_valid, 1);
        @(posedge clk); #1;
        clr_in(); b_valid = 1; b_resp = 2'b01;
        @(negedge clk); chk("awdone_awv", aw_valid, 0); chk("wfirst_bready", b_ready, 1);
        @(posedge clk); #1;
        clr_in();
        @(negedge clk);
        chk("wfirst_rvalid", rvalid, 1); chk("exokay_err", err, 0); chk("wfirst_rdata", rdata, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pulse_end_rvalid", rvalid, 0); chk("idle_bready", b_ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
